// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the D-stage decoder and the hazard controller.
// The decoder side (master) supplies decoded D-stage fields and the E-stage
// MD start strobe; the controller side (slave) returns the stall and the
// forwarding-mux selects.
interface hazard_ctrl_if;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [1:0] tuse_rs_d;
    logic [1:0] tuse_rt_d;
    logic [4:0] wa_d;
    logic [1:0] tnew_d;
    logic       md_d;
    logic       md_start_e;
    logic       md_div_e;

    logic       stall;
    logic [1:0] fwd_rs_d;
    logic [1:0] fwd_rt_d;
    logic [1:0] fwd_rs_e;
    logic [1:0] fwd_rt_e;
    logic       md_busy;

    modport master (
        output rs_d, rt_d, tuse_rs_d, tuse_rt_d, wa_d, tnew_d,
               md_d, md_start_e, md_div_e,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
    );

    modport slave (
        input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, wa_d, tnew_d,
               md_d, md_start_e, md_div_e,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage MIPS core.
// Shadows the destination register and result readiness (Tnew) of the
// instructions in E, M and W, stalls D when an operand cannot be supplied
// in time, picks forwarding sources for D and E operands, and counts down
// the busy period of the multi-cycle multiply/divide unit.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    hazard_ctrl_if.slave  hz
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_E    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] FWD_W    = 2'b11;

    // Shadow registers for E, M and W, plus the MD busy counter
    logic [4:0] rs_e_q,   rs_e_d;
    logic [4:0] rt_e_q,   rt_e_d;
    logic [4:0] wa_e_q,   wa_e_d;
    logic [1:0] tnew_e_q, tnew_e_d;
    logic [4:0] wa_m_q,   wa_m_d;
    logic [1:0] tnew_m_q, tnew_m_d;
    logic [4:0] wa_w_q,   wa_w_d;
    logic [3:0] md_cnt_q, md_cnt_d;

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall_int;
    logic busy_int;

    // A D operand must wait if the producer in E or M will not have its
    // result before the operand is consumed. Register 0 and unused operands
    // never stall.
    function automatic logic operand_stall(
        input logic [4:0] r,
        input logic [1:0] tuse,
        input logic [4:0] wa_e,
        input logic [1:0] tnew_e,
        input logic [4:0] wa_m,
        input logic [1:0] tnew_m
    );
        logic hit;
        hit = 1'b0;
        if (tuse != TUSE_NONE && r != 5'd0) begin
            if (r == wa_e && tnew_e > tuse) begin
                hit = 1'b1;
            end else if (r == wa_m && tnew_m > tuse) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // D-operand source: nearest stage whose result already exists.
    function automatic logic [1:0] fwd_sel_d(
        input logic [4:0] r,
        input logic [4:0] wa_e,
        input logic [1:0] tnew_e,
        input logic [4:0] wa_m,
        input logic [1:0] tnew_m,
        input logic [4:0] wa_w
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (r != 5'd0) begin
            if (r == wa_e && tnew_e == 2'd0) begin
                sel = FWD_E;
            end else if (r == wa_m && tnew_m == 2'd0) begin
                sel = FWD_M;
            end else if (r == wa_w) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    // E-operand source: M result if ready, else W write-back data.
    function automatic logic [1:0] fwd_sel_e(
        input logic [4:0] r,
        input logic [4:0] wa_m,
        input logic [1:0] tnew_m,
        input logic [4:0] wa_w
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (r != 5'd0) begin
            if (r == wa_m && tnew_m == 2'd0) begin
                sel = FWD_M;
            end else if (r == wa_w) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    // Stall decision and forwarding selects from the shadows and D fields
    always_comb begin
        stall_rs  = operand_stall(hz.rs_d, hz.tuse_rs_d, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q);
        stall_rt  = operand_stall(hz.rt_d, hz.tuse_rt_d, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q);
        busy_int  = (md_cnt_q != 4'd0);
        stall_md  = hz.md_d && (busy_int || hz.md_start_e);
        stall_int = stall_rs || stall_rt || stall_md;

        hz.stall    = reset_n && stall_int;
        hz.md_busy  = reset_n && busy_int;
        hz.fwd_rs_d = FWD_NONE;
        hz.fwd_rt_d = FWD_NONE;
        hz.fwd_rs_e = FWD_NONE;
        hz.fwd_rt_e = FWD_NONE;
        if (reset_n) begin
            hz.fwd_rs_d = fwd_sel_d(hz.rs_d, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q, wa_w_q);
            hz.fwd_rt_d = fwd_sel_d(hz.rt_d, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q, wa_w_q);
            hz.fwd_rs_e = fwd_sel_e(rs_e_q, wa_m_q, tnew_m_q, wa_w_q);
            hz.fwd_rt_e = fwd_sel_e(rt_e_q, wa_m_q, tnew_m_q, wa_w_q);
        end
    end

    // Next shadow state: advance the pipeline, inserting a bubble into E on
    // stall, and step the MD busy counter (a start while busy is ignored)
    always_comb begin
        rs_e_d   = 5'd0;
        rt_e_d   = 5'd0;
        wa_e_d   = 5'd0;
        tnew_e_d = 2'd0;
        if (!stall_int) begin
            rs_e_d   = hz.rs_d;
            rt_e_d   = hz.rt_d;
            wa_e_d   = hz.wa_d;
            tnew_e_d = hz.tnew_d;
        end

        wa_m_d   = wa_e_q;
        tnew_m_d = (tnew_e_q == 2'd0) ? 2'd0 : tnew_e_q - 2'd1;
        wa_w_d   = wa_m_q;

        md_cnt_d = md_cnt_q;
        if (hz.md_start_e && md_cnt_q == 4'd0) begin
            md_cnt_d = hz.md_div_e ? DIV_LOAD : MULT_LOAD;
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end
    end

    // Shadow and counter registers, cleared asynchronously on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rs_e_q   <= 5'd0;
            rt_e_q   <= 5'd0;
            wa_e_q   <= 5'd0;
            tnew_e_q <= 2'd0;
            wa_m_q   <= 5'd0;
            tnew_m_q <= 2'd0;
            wa_w_q   <= 5'd0;
            md_cnt_q <= 4'd0;
        end else begin
            rs_e_q   <= rs_e_d;
            rt_e_q   <= rt_e_d;
            wa_e_q   <= wa_e_d;
            tnew_e_q <= tnew_e_d;
            wa_m_q   <= wa_m_d;
            tnew_m_q <= tnew_m_d;
            wa_w_q   <= wa_w_d;
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each step drives D-stage fields on the
// falling edge, queues the expected outputs, and compares them shortly after.
module tb_hazard_ctrl;

    logic clk;
    logic reset_n;

    hazard_ctrl_if hz ();

    hazard_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } expT;

    expT sb[$];
    int  total = 0;
    int  bad   = 0;

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one set of D-stage fields at the falling edge
    task automatic applyStimulus(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [1:0] trs,
        input logic [1:0] trt,
        input logic [4:0] wa,
        input logic [1:0] tnew,
        input logic       md,
        input logic       start,
        input logic       isDiv
    );
        @(negedge clk);
        hz.rs_d       = rs;
        hz.rt_d       = rt;
        hz.tuse_rs_d  = trs;
        hz.tuse_rt_d  = trt;
        hz.wa_d       = wa;
        hz.tnew_d     = tnew;
        hz.md_d       = md;
        hz.md_start_e = start;
        hz.md_div_e   = isDiv;
    endtask

    task automatic idle();
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Queue the expected {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy}
    task automatic expectOut(
        input string      tag,
        input logic       st,
        input logic [1:0] frsd,
        input logic [1:0] frtd,
        input logic [1:0] frse,
        input logic [1:0] frte,
        input logic       busy
    );
        expT e;
        e.tag = tag;
        e.exp = {st, frsd, frtd, frse, frte, busy};
        sb.push_back(e);
    endtask

    // Let combinational outputs settle, then compare against the queue
    task automatic checkOutput();
        expT        e;
        logic [9:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = {hz.stall, hz.fwd_rs_d, hz.fwd_rt_d, hz.fwd_rs_e, hz.fwd_rt_e, hz.md_busy};
            total++;
            assert (obs === e.exp) else begin
                bad++;
                $error("[TB] FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
            end
        end
    endtask

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    // Directed sequence
    initial begin
        reset_n = 1'b0;
        hz.rs_d = 5'd0; hz.rt_d = 5'd0; hz.tuse_rs_d = 2'd3; hz.tuse_rt_d = 2'd3;
        hz.wa_d = 5'd0; hz.tnew_d = 2'd0; hz.md_d = 1'b0; hz.md_start_e = 1'b0; hz.md_div_e = 1'b0;

        idle(); expectOut("reset_state", 0, 2'b00, 2'b00, 2'b00, 2'b00, 0); checkOutput();
        reset_n = 1'b1;

        // Reset in the middle of a divide (count 7)
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1);
        expectOut("md_start", 0, 2'b00, 2'b00, 2'b00, 2'b00, 0); checkOutput();
        for (int i = 0; i < 3; i++) begin
            idle(); expectOut("md_busy_pre", 0, 2'b00, 2'b00, 2'b00, 2'b00, 1); checkOutput();
        end
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
        reset_n = 1'b0;
        expectOut("rst_mid_md", 0, 2'b00, 2'b00, 2'b00, 2'b00, 0); checkOutput();
        idle(); expectOut("rst_hold", 0, 2'b00, 2'b00, 2'b00, 2'b00, 0); checkOutput();
        reset_n = 1'b1;
        idle(); expectOut("after_rst", 0, 2'b00, 2'b00, 2'b00, 2'b00, 0); checkOutput();

        // Load-use: lw $8 then add rs=$8
        applyStimulus(5'd29, 5'd0, 2'd1, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
        expectOut("lu_lw", 0, 2'b00, 2'b00, 2'b00, 2'b00, 0); checkOutput();
        applyStimulus(5'd8, 5'd9, 2'd1, 2'd1, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0);
        expectOut("lu_stall", 1, 2'b00, 2'b00, 2'b00, 2'b00, 0); checkOutput();
        applyStimulus(5'd8, 5'd9, 2'd1, 2'd1, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0);
        expectOut("lu_issue", 0, 2'b00, 2'b00, 2'b00, 2'b00, 0); checkOutput();
        idle(); expectOut("lu_fwd_e_w", 0, 2'b00, 2'b00, 2'b11, 2'b00, 0); checkOutput();

        // Branch after ALU: addu $9 then beq rs=$9
        applyStimulus(5'd1, 5'd2, 2'd1, 2'd1, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);
        expectOut("br_addu", 0, 2'b00, 2'b00, 2'b00, 2'b00, 0); checkOutput();
        applyStimulus(5'd9, 5'd3, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        expectOut("br_stall", 1, 2'b00, 2'b00, 2'b00, 2'b00, 0); checkOutput();
        applyStimulus(5'd9, 5'd3, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        expectOut("br_fwd_m", 0, 2'b10, 2'b00, 2'b00, 2'b00, 0); checkOutput();

        // jal then jr $31
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0);
        expectOut("jal_fwd_e_w", 0, 2'b00, 2'b00, 2'b11, 2'b00, 0); checkOutput();
        applyStimulus(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        expectOut("jr_fwd_e", 0, 2'b01, 2'b00, 2'b00, 2'b00, 0); checkOutput();

        // Register 0 never stalls or forwards; jr's rs forwards from M in E
        applyStimulus(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        expectOut("reg0", 0, 2'b00, 2'b00, 2'b10, 2'b00, 0); checkOutput();
        applyStimulus(5'd31, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        expectOut("d_fwd_w", 0, 2'b11, 2'b00, 2'b00, 2'b00, 0); checkOutput();

        // rt path: two writers of $5, branch on rt=$5
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
        expectOut("rt_lw", 0, 2'b00, 2'b00, 2'b00, 2'b00, 0); checkOutput();
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);
        expectOut("rt_addi", 0, 2'b00, 2'b00, 2'b00, 2'b00, 0); checkOutput();
        applyStimulus(5'd0, 5'd5, 2'd3, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        expectOut("rt_stall", 1, 2'b00, 2'b00, 2'b00, 2'b00, 0); checkOutput();
        applyStimulus(5'd0, 5'd5, 2'd3, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        expectOut("rt_fwd_m_over_w", 0, 2'b00, 2'b10, 2'b00, 2'b00, 0); checkOutput();
        idle(); expectOut("rt_fwd_e_w", 0, 2'b00, 2'b00, 2'b00, 2'b11, 0); checkOutput();

        // Divide start with mflo waiting in D
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b1, 1'b1, 1'b1);
        expectOut("div_start", 1, 2'b00, 2'b00, 2'b00, 2'b00, 0); checkOutput();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b1, 1'b0, 1'b0);
            expectOut("div_busy", 1, 2'b00, 2'b00, 2'b00, 2'b00, 1); checkOutput();
        end
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b1, 1'b0, 1'b0);
        expectOut("div_issue", 0, 2'b00, 2'b00, 2'b00, 2'b00, 0); checkOutput();

        // Multiply start with mflo waiting in D
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b1, 1'b1, 1'b0);
        expectOut("mult_start", 1, 2'b00, 2'b00, 2'b00, 2'b00, 0); checkOutput();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b1, 1'b0, 1'b0);
            expectOut("mult_busy", 1, 2'b00, 2'b00, 2'b00, 2'b00, 1); checkOutput();
        end
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b1, 1'b0, 1'b0);
        expectOut("mult_issue", 0, 2'b00, 2'b00, 2'b00, 2'b00, 0); checkOutput();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
